// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU/mul-div opcodes, forwarding selects
// and the iterative mul/div state encoding.
package ex_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_LUI   = 5'd10,
    ALU_AUIPC = 5'd11,
    MD_MUL    = 5'd16,
    MD_MULH   = 5'd17,
    MD_MULHSU = 5'd18,
    MD_MULHU  = 5'd19,
    MD_DIV    = 5'd20,
    MD_DIVU   = 5'd21,
    MD_REM    = 5'd22,
    MD_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op[4:2] == 3'b101);
  endfunction

  // MULHSU treats only operand A as signed.
  function automatic logic op_a_signed(input logic [4:0] op);
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic op_b_signed(input logic [4:0] op);
    case (op)
      MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, one step per cycle, sign fix-up applied in the DONE state.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(MD_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MD_STEPS - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d, div0_q, div0_d;
  logic [XLEN-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;

  logic            sa_in_s, sb_in_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, res_s;
  logic [XLEN:0]   sum_s, shifted_s, diff_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  assign sa_in_s = op_a_signed(op_i) & a_i[XLEN-1];
  assign sb_in_s = op_b_signed(op_i) & b_i[XLEN-1];
  assign mag_a_s = sa_in_s ? -a_i : a_i;
  assign mag_b_s = sb_in_s ? -b_i : b_i;

  // hi:lo is the running product (mul) or remainder:quotient (div).
  assign sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign shifted_s = {hi_q, lo_q[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, opnd_q};

  // Next-state for the FSM, counter and operand/accumulator registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div0_d  = div0_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush_i) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_d = MD_BUSY;
            cnt_d   = {CW{1'b0}};
            op_d    = alu_op_e'(op_i);
            sa_d    = sa_in_s;
            sb_d    = sb_in_s;
            hi_d    = {XLEN{1'b0}};
            if (is_div_op(op_i)) begin
              lo_d   = mag_a_s;
              opnd_d = mag_b_s;
              div0_d = (b_i == {XLEN{1'b0}});
            end else begin
              lo_d   = mag_b_s;
              opnd_d = mag_a_s;
              div0_d = 1'b0;
            end
          end else begin
            state_d = MD_IDLE;
          end
        end
        MD_BUSY: begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (is_div_op(op_q)) begin
            if (!diff_s[XLEN]) begin
              hi_d = diff_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = shifted_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = sum_s[XLEN:1];
            lo_d = {sum_s[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == LAST_STEP) begin
            state_d = MD_DONE;
          end else begin
            state_d = MD_BUSY;
          end
        end
        MD_DONE: state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= ALU_ADD;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      opnd_q  <= {XLEN{1'b0}};
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign prod_s     = {hi_q, lo_q};
  assign prod_fix_s = (sa_q ^ sb_q) ? -prod_s : prod_s;

  // Sign fix-up; divide-by-zero quotient bypasses it, remainder follows the dividend.
  always_comb begin
    res_s = {XLEN{1'b0}};
    case (op_q)
      MD_MUL:                      res_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             res_s = div0_q ? {XLEN{1'b1}} : ((sa_q ^ sb_q) ? -lo_q : lo_q);
      MD_REM, MD_REMU:             res_s = sa_q ? -hi_q : hi_q;
      default:                     res_s = {XLEN{1'b0}};
    endcase
  end

  assign busy_o   = (state_q != MD_DONE);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = done_o ? res_s : {XLEN{1'b0}};

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand forwarding, single-cycle ALU and gating of the
// iterative mul/div unit into the pipeline stall.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [4:0]      alu_op,
  input  logic            alu_src_b,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] mem_wb_write_data,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] store_data,
  output logic            result_valid,
  output logic            ex_busy
);

  alu_op_e         op_s;
  logic [XLEN-1:0] opa_s, fwd_b_s, opb_s, alu_res_s, md_res_s;
  logic [4:0]      shamt_s;
  logic            m_op_s, md_start_s, md_busy_s, md_done_s;

  assign op_s   = alu_op_e'(alu_op);
  assign m_op_s = is_md_op(alu_op);

  // Operand forwarding; the unused 2'b11 select falls back to the register file.
  always_comb begin
    case (fwd_sel_e'(forward_a))
      FWD_MEM: opa_s = ex_mem_alu_result;
      FWD_WB:  opa_s = mem_wb_write_data;
      default: opa_s = rs1_data;
    endcase
    case (fwd_sel_e'(forward_b))
      FWD_MEM: fwd_b_s = ex_mem_alu_result;
      FWD_WB:  fwd_b_s = mem_wb_write_data;
      default: fwd_b_s = rs2_data;
    endcase
  end

  assign opb_s      = alu_src_b ? imm : fwd_b_s;
  assign store_data = fwd_b_s;
  assign shamt_s    = opb_s[4:0];

  // Single-cycle RV32I ALU.
  always_comb begin
    case (op_s)
      ALU_ADD:   alu_res_s = opa_s + opb_s;
      ALU_SUB:   alu_res_s = opa_s - opb_s;
      ALU_SLL:   alu_res_s = opa_s << shamt_s;
      ALU_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
      ALU_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (opa_s < opb_s)};
      ALU_XOR:   alu_res_s = opa_s ^ opb_s;
      ALU_SRL:   alu_res_s = opa_s >> shamt_s;
      ALU_SRA:   alu_res_s = $unsigned($signed(opa_s) >>> shamt_s);
      ALU_OR:    alu_res_s = opa_s | opb_s;
      ALU_AND:   alu_res_s = opa_s & opb_s;
      ALU_LUI:   alu_res_s = opb_s;
      ALU_AUIPC: alu_res_s = pc + opb_s;
      default:   alu_res_s = {XLEN{1'b0}};
    endcase
  end

  assign md_start_s = valid_in & m_op_s & ~flush;

  muldiv_iter #(
    .XLEN     (XLEN),
    .MD_STEPS (MD_STEPS)
  ) u_muldiv (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (md_start_s),
    .op_i     (alu_op),
    .a_i      (opa_s),
    .b_i      (opb_s),
    .flush_i  (flush),
    .busy_o   (md_busy_s),
    .done_o   (md_done_s),
    .result_o (md_res_s)
  );

  // Output gating: reset and flush suppress results; M ops stall until DONE.
  always_comb begin
    if (rst) begin
      result       = {XLEN{1'b0}};
      result_valid = 1'b0;
      ex_busy      = 1'b0;
    end else begin
      result       = m_op_s ? md_res_s : alu_res_s;
      result_valid = ~flush & (m_op_s ? md_done_s : valid_in);
      ex_busy      = valid_in & m_op_s & md_busy_s & ~flush;
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32IM pipeline. Sits downstream of the forwarding unit and consumes its `forward_a`/`forward_b` selects. Picks each ALU operand from the register file, the EX/MEM result or the MEM/WB write-back data, then computes the result. RV32I ops finish in one cycle; RV32M multiply/divide ops run on an iterative 32-step unit that stalls the front end through `ex_busy`.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `MD_STEPS`, 32, iterations per multiply/divide; must equal `XLEN`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `valid_in` in 1: ID/EX holds a live instruction.
- `alu_op` in 5: operation code, `ex_pkg::alu_op_e`.
- `alu_src_b` in 1: 1 = operand B is `imm`, 0 = forwarded rs2.
- `rs1_data`, `rs2_data` in XLEN: register-file values latched in ID/EX.
- `imm`, `pc` in XLEN: immediate and instruction PC (AUIPC uses `pc`).
- `forward_a`, `forward_b` in 2: 00 regfile, 01 `ex_mem_alu_result`, 10 `mem_wb_write_data`, 11 treated as 00.
- `ex_mem_alu_result`, `mem_wb_write_data` in XLEN: forwarding sources.
- `flush` in 1: kill the current instruction, including an in-flight mul/div.
- `result` out XLEN: ALU or mul/div result.
- `store_data` out XLEN: forwarded rs2, before the `alu_src_b` mux.
- `result_valid` out 1: `result` is meaningful this cycle.
- `ex_busy` out 1: hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.

## Operation
- Operand A = fwd(rs1); operand B = `alu_src_b` ? `imm` : fwd(rs2).
- RV32I ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI (passes B), AUIPC (`pc`+B).
  - Shifts use B[4:0].
  - Result is combinational, `result_valid = valid_in & ~flush`.
- M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Mul/div FSM states: IDLE, BUSY, DONE.
- IDLE→BUSY when `valid_in` & M op & ~`flush`.
  - Latch forwarded operands, operand signs and op.
  - Load magnitudes; counter = 0.
  - The latch is mandatory: forwarding sources change while the pipeline is stalled.
- BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle, counter += 1.
  - At counter = `MD_STEPS`-1, go to DONE.
- DONE: apply the sign fix-up, drive `result`, `result_valid` = 1, then go to IDLE.
- Multiply: 64-bit unsigned product of magnitudes, negated if signs differ.
  - MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
  - MULHSU treats only A as signed.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (−2^31 / −1): quotient = −2^31, remainder = 0.
- `ex_busy` = `valid_in` & M op & (state ≠ DONE) & ~`flush`.
- `flush` in any state: FSM goes to IDLE next cycle, `result_valid` = 0 that cycle, no result produced.
- `rst`: state IDLE, counter 0, operand/accumulator registers 0.
  - While `rst` is high, `result_valid` = 0, `ex_busy` = 0 and `result` = 0.
- Back-to-back M ops: the DONE→IDLE cycle coincides with ID/EX loading the next instruction. The next op is issued from IDLE in that following cycle.

## Timing
- ALU op: 0-cycle latency; result is captured into EX/MEM at the same edge.
- M op issued in cycle T:
  - `ex_busy` is high in T..T+32.
  - `result_valid` and `result` are valid in T+33, with `ex_busy` low.
  - EX/MEM captures at the end of T+33.
  - Total occupancy of EX is 34 cycles.
- `flush` at any cycle T+k: `ex_busy` goes low in the same cycle and the FSM is IDLE at T+k+1.
- Reset mid-operation: IDLE on the next edge; no stale result may appear after reset deasserts.

## Structure
- `ex_pkg`: `alu_op_e` enum, `fwd_sel_e` (FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10), `md_state_e`.
  - The forwarding unit imports the same `fwd_sel_e`.
- Sub-module `muldiv_iter` holds the FSM, counter, accumulators and sign logic. It has a start/op/a/b/flush in, busy/done/result out interface.
- `ex_stage` holds the forwarding muxes, the ALU and the busy gating.

## Test plan
- Forwarding select: `rs1_data` = 1, `ex_mem_alu_result` = 5, `mem_wb_write_data` = 9, ADD with B = imm 0.
  - `forward_a` 00/01/10/11 → `result` 1/5/9/1.
- `forward_b` = 01, `alu_src_b` = 1, `imm` = 4 → `store_data` = `ex_mem_alu_result`, `result` uses 4.
- MUL −3 × 7 issued in T → `ex_busy` high T..T+32; T+33 `result` = 0xFFFFFFEB, `result_valid` = 1.
  - Change forwarding sources during T+1..T+32 → result unchanged.
- Divide edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - DIVU 7 / 0 → 0xFFFFFFFF.
  - REMU 7 / 0 → 7.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Issue DIV, assert `flush` at T+10 → `ex_busy` low at T+10, no `result_valid` afterwards.
  - Same test with `rst` at T+10 → IDLE at T+11.
  - A following ADD completes in one cycle.
